// File: rtl/rf_trace_monitor.sv
// Register-file write tracer: records architectural writes with timestamps into a circular
// buffer with FWFT readout, and flags end of program (pc stall) or runaway (cycle timeout).
module rf_trace_monitor #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned TS_W        = 16,
  parameter int unsigned WRAP        = 1,
  parameter int unsigned HALT_CYCLES = 4,
  parameter int unsigned TIMEOUT     = 60,
  localparam int unsigned PTR_W      = $clog2(DEPTH),
  localparam int unsigned CNT_W      = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clear,
  input  logic              rf_we,
  input  logic [ADDR_W-1:0] rf_waddr,
  input  logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] pc,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [TS_W-1:0]   rd_ts,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              halted,
  output logic              timeout,
  output logic [1:0]        state
);

  localparam int unsigned HC_W = $clog2(HALT_CYCLES) + 1;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StCapture = 2'b01,
    StDone    = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic [TS_W-1:0]     cyc_q, cyc_d;
  logic [DATA_W-1:0]   pc_prev_q;
  logic [HC_W-1:0]     stall_q, stall_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                halted_q, halted_d;
  logic                timeout_q, timeout_d;

  logic [ADDR_W-1:0]   mem_addr_q [DEPTH];
  logic [DATA_W-1:0]   mem_data_q [DEPTH];
  logic [TS_W-1:0]     mem_ts_q   [DEPTH];

  logic mem_we;
  logic push, pop, full, halt_hit, to_hit, pc_match;

  assign rd_valid = (count_q != '0);
  assign pop      = rd_valid & rd_ready;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign push     = (state_q == StCapture) & rf_we & (rf_waddr != '0);
  assign pc_match = (pc == pc_prev_q);

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    stall_d    = stall_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    halted_d   = halted_q;
    timeout_d  = timeout_q;
    mem_we     = 1'b0;
    halt_hit   = 1'b0;
    to_hit     = 1'b0;

    unique case (state_q)
      StIdle: begin
        stall_d = '0;
        if (start) begin
          state_d = StCapture;
          cyc_d   = '0;
        end
      end
      StCapture: begin
        stall_d  = pc_match ? stall_q + 1'b1 : '0;
        halt_hit = pc_match && ((stall_q + 1'b1) == HC_W'(HALT_CYCLES - 1));
        to_hit   = (cyc_q == TS_W'(TIMEOUT - 1));
        if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
        if (halt_hit) halted_d = 1'b1;
        if (to_hit) timeout_d = 1'b1;
        if (halt_hit || to_hit) state_d = StDone;
      end
      StDone: stall_d = '0;
      default: state_d = StIdle;
    endcase

    if (push) begin
      if (!full || pop) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        else     count_d  = count_q + 1'b1;
      end else if (WRAP != 0) begin
        // Full without a pop: overwrite the oldest entry and drag the read pointer along.
        mem_we     = 1'b1;
        wr_ptr_d   = wr_ptr_q + 1'b1;
        rd_ptr_d   = rd_ptr_q + 1'b1;
        overflow_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q - 1'b1;
    end

    if (clear) begin
      state_d    = StIdle;
      cyc_d      = '0;
      stall_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      halted_d   = 1'b0;
      timeout_d  = 1'b0;
      mem_we     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cyc_q      <= '0;
      pc_prev_q  <= '0;
      stall_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      halted_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      pc_prev_q  <= pc;
      stall_q    <= stall_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      halted_q   <= halted_d;
      timeout_q  <= timeout_d;
    end
  end

  // Storage needs no reset: readout is gated by count.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_addr_q[wr_ptr_q] <= rf_waddr;
      mem_data_q[wr_ptr_q] <= rf_wdata;
      mem_ts_q[wr_ptr_q]   <= cyc_q;
    end
  end

  assign rd_addr  = rd_valid ? mem_addr_q[rd_ptr_q] : '0;
  assign rd_data  = rd_valid ? mem_data_q[rd_ptr_q] : '0;
  assign rd_ts    = rd_valid ? mem_ts_q[rd_ptr_q]   : '0;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign halted   = halted_q;
  assign timeout  = timeout_q;
  assign state    = state_q;

endmodule

// File: tb/tb_rf_trace_monitor.sv
// Scoreboard bench for rf_trace_monitor: one default instance plus two DEPTH=4 instances
// (overwrite and drop modes) sharing stimulus, each with its own drain handshake.
module tb_rf_trace_monitor;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic [15:0] t;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        rf_we = 1'b0;
  logic [4:0]  rf_waddr = '0;
  logic [31:0] rf_wdata = '0;
  logic [31:0] pc = '0;
  logic        rdy_m = 1'b0, rdy_w1 = 1'b0, rdy_w0 = 1'b0;

  logic        v_m, v_w1, v_w0;
  logic [4:0]  a_m, a_w1, a_w0;
  logic [31:0] d_m, d_w1, d_w0;
  logic [15:0] t_m, t_w1, t_w0;
  logic [4:0]  cnt_m;
  logic [2:0]  cnt_w1, cnt_w0;
  logic        ovf_m, ovf_w1, ovf_w0;
  logic        hlt_m, hlt_w1, hlt_w0;
  logic        to_m, to_w1, to_w0;
  logic [1:0]  st_m, st_w1, st_w0;

  int n_checks = 0;
  int n_fail = 0;
  ent_t q_m[$], q_w1[$], q_w0[$];
  logic cap_model = 1'b0;
  logic pc_run = 1'b1;
  logic [15:0] ts_model = '0;

  always #5 clk = ~clk;

  rf_trace_monitor u_dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc(pc), .rd_ready(rdy_m), .rd_valid(v_m),
    .rd_addr(a_m), .rd_data(d_m), .rd_ts(t_m), .count(cnt_m), .overflow(ovf_m),
    .halted(hlt_m), .timeout(to_m), .state(st_m)
  );

  rf_trace_monitor #(.DEPTH(4), .WRAP(1)) u_w1 (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc(pc), .rd_ready(rdy_w1), .rd_valid(v_w1),
    .rd_addr(a_w1), .rd_data(d_w1), .rd_ts(t_w1), .count(cnt_w1), .overflow(ovf_w1),
    .halted(hlt_w1), .timeout(to_w1), .state(st_w1)
  );

  rf_trace_monitor #(.DEPTH(4), .WRAP(0)) u_w0 (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc(pc), .rd_ready(rdy_w0), .rd_valid(v_w0),
    .rd_addr(a_w0), .rd_data(d_w0), .rd_ts(t_w0), .count(cnt_w0), .overflow(ovf_w0),
    .halted(hlt_w0), .timeout(to_w0), .state(st_w0)
  );

  task automatic step();
    @(posedge clk);
    #1;
    if (cap_model) ts_model = ts_model + 16'd1;
    if (pc_run) pc = pc + 32'd4;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    cap_model = 1'b1;
    ts_model = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    cap_model = 1'b0;
    q_m.delete();
    q_w1.delete();
    q_w0.delete();
  endtask

  // Drives one write cycle and updates the three reference models.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    ent_t e;
    e = '{a: a, d: d, t: ts_model};
    if (cap_model && a != 5'd0) begin
      if (q_m.size() == 16) void'(q_m.pop_front());
      q_m.push_back(e);
      if (q_w1.size() == 4) void'(q_w1.pop_front());
      q_w1.push_back(e);
      if (q_w0.size() < 4) q_w0.push_back(e);
    end
    rf_we = 1'b1;
    rf_waddr = a;
    rf_wdata = d;
    step();
    rf_we = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    n_checks++;
    if ({st_m, cnt_m, v_m, ovf_m, hlt_m, to_m} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got=%0h exp=0", {st_m, cnt_m, v_m, ovf_m, hlt_m, to_m});
    end
    n_checks++;
    if ({a_m, d_m, t_m} !== '0) begin
      n_fail++;
      $display("FAIL reset_rd got=%0h exp=0", {a_m, d_m, t_m});
    end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_capture();
    ent_t e;
    int n;
    do_clear();
    do_start();
    step();
    step();
    do_write(5'd8, 32'd5);
    do_write(5'd9, 32'd7);
    do_write(5'd0, 32'd9);
    n_checks++;
    if (cnt_m !== 5'(q_m.size())) begin
      n_fail++;
      $display("FAIL capture_count got=%0d exp=%0d", cnt_m, q_m.size());
    end
    n_checks++;
    if (st_m !== 2'b01) begin
      n_fail++;
      $display("FAIL capture_state got=%0d exp=1", st_m);
    end
    n = q_m.size();
    rdy_m = 1'b1;
    for (int i = 0; i < n; i++) begin
      e = q_m.pop_front();
      n_checks++;
      if ({v_m, a_m, d_m, t_m} !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL capture_drain%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", i, a_m, d_m, t_m,
                 e.a, e.d, e.t);
      end
      step();
    end
    rdy_m = 1'b0;
    n_checks++;
    if ({v_m, cnt_m, a_m, d_m, t_m} !== '0) begin
      n_fail++;
      $display("FAIL capture_empty got=%0h exp=0", {v_m, cnt_m, a_m, d_m, t_m});
    end
  endtask

  task automatic test_wrap();
    ent_t e;
    int n;
    do_clear();
    do_start();
    for (int i = 0; i < 6; i++) do_write(5'(8 + i), 32'(i + 1));
    n_checks++;
    if ({cnt_w1, ovf_w1} !== {3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL wrap1_full got=%0d/%0b exp=4/1", cnt_w1, ovf_w1);
    end
    n_checks++;
    if ({cnt_w0, ovf_w0} !== {3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL wrap0_full got=%0d/%0b exp=4/1", cnt_w0, ovf_w0);
    end
    n_checks++;
    if ({cnt_m, ovf_m} !== {5'd6, 1'b0}) begin
      n_fail++;
      $display("FAIL main_no_ovf got=%0d/%0b exp=6/0", cnt_m, ovf_m);
    end
    n = q_w1.size();
    rdy_w1 = 1'b1;
    for (int i = 0; i < n; i++) begin
      e = q_w1.pop_front();
      n_checks++;
      if ({v_w1, a_w1, d_w1, t_w1} !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL wrap1_drain%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", i, a_w1, d_w1, t_w1,
                 e.a, e.d, e.t);
      end
      step();
    end
    rdy_w1 = 1'b0;
    n = q_w0.size();
    rdy_w0 = 1'b1;
    for (int i = 0; i < n; i++) begin
      e = q_w0.pop_front();
      n_checks++;
      if ({v_w0, a_w0, d_w0, t_w0} !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL wrap0_drain%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", i, a_w0, d_w0, t_w0,
                 e.a, e.d, e.t);
      end
      step();
    end
    rdy_w0 = 1'b0;
    n_checks++;
    if ({v_w1, v_w0} !== 2'b00) begin
      n_fail++;
      $display("FAIL wrap_empty got=%0b exp=00", {v_w1, v_w0});
    end
  endtask

  task automatic test_full_push_pop();
    ent_t e;
    int n;
    do_clear();
    do_start();
    for (int i = 0; i < 4; i++) do_write(5'(1 + i), 32'(16 * (i + 1)));
    e = q_w0.pop_front();
    n_checks++;
    if ({v_w0, a_w0, d_w0, t_w0} !== {1'b1, e}) begin
      n_fail++;
      $display("FAIL pushpop_head got=%0h/%0h exp=%0h/%0h", a_w0, d_w0, e.a, e.d);
    end
    rdy_w0 = 1'b1;
    do_write(5'd5, 32'd80);
    rdy_w0 = 1'b0;
    n_checks++;
    if ({cnt_w0, ovf_w0} !== {3'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL pushpop_full got=%0d/%0b exp=4/0", cnt_w0, ovf_w0);
    end
    n = q_w0.size();
    rdy_w0 = 1'b1;
    for (int i = 0; i < n; i++) begin
      e = q_w0.pop_front();
      n_checks++;
      if ({v_w0, a_w0, d_w0, t_w0} !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL pushpop_drain%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", i, a_w0, d_w0, t_w0,
                 e.a, e.d, e.t);
      end
      step();
    end
    rdy_w0 = 1'b0;
  endtask

  task automatic test_halt();
    ent_t e;
    do_clear();
    pc_run = 1'b0;
    pc = 32'd100;
    do_start();
    pc = 32'h0;
    step();
    pc = 32'h4;
    do_write(5'd5, 32'h55);
    pc = 32'h8;
    step();
    pc = 32'hC;
    step();
    step();
    step();
    n_checks++;
    if ({hlt_m, st_m} !== {1'b0, 2'b01}) begin
      n_fail++;
      $display("FAIL halt_early got=%0b/%0d exp=0/1", hlt_m, st_m);
    end
    step();
    cap_model = 1'b0;
    n_checks++;
    if ({hlt_m, to_m, st_m} !== {1'b1, 1'b0, 2'b10}) begin
      n_fail++;
      $display("FAIL halt_done got=%0b/%0b/%0d exp=1/0/2", hlt_m, to_m, st_m);
    end
    do_write(5'd6, 32'h66);
    n_checks++;
    if (cnt_m !== 5'(q_m.size())) begin
      n_fail++;
      $display("FAIL halt_nocap got=%0d exp=%0d", cnt_m, q_m.size());
    end
    e = q_m.pop_front();
    n_checks++;
    if ({v_m, a_m, d_m, t_m} !== {1'b1, e}) begin
      n_fail++;
      $display("FAIL halt_drain got=%0h/%0h/%0h exp=%0h/%0h/%0h", a_m, d_m, t_m, e.a, e.d, e.t);
    end
    rdy_m = 1'b1;
    step();
    rdy_m = 1'b0;
    n_checks++;
    if ({v_m, hlt_m} !== 2'b01) begin
      n_fail++;
      $display("FAIL halt_after_drain got=%0b exp=01", {v_m, hlt_m});
    end
    pc_run = 1'b1;
  endtask

  task automatic test_timeout();
    do_clear();
    do_start();
    for (int i = 0; i < 59; i++) step();
    n_checks++;
    if ({to_m, st_m} !== {1'b0, 2'b01}) begin
      n_fail++;
      $display("FAIL timeout_early got=%0b/%0d exp=0/1", to_m, st_m);
    end
    step();
    cap_model = 1'b0;
    n_checks++;
    if ({to_m, hlt_m, st_m} !== {1'b1, 1'b0, 2'b10}) begin
      n_fail++;
      $display("FAIL timeout_done got=%0b/%0b/%0d exp=1/0/2", to_m, hlt_m, st_m);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if ({to_m, st_m} !== {1'b1, 2'b10}) begin
      n_fail++;
      $display("FAIL timeout_sticky got=%0b/%0d exp=1/2", to_m, st_m);
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    do_start();
    for (int i = 0; i < 3; i++) do_write(5'(20 + i), 32'(i + 100));
    n_checks++;
    if (cnt_m !== 5'd3) begin
      n_fail++;
      $display("FAIL arst_pre_count got=%0d exp=3", cnt_m);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({st_m, cnt_m, v_m, a_m, d_m, t_m} !== '0) begin
      n_fail++;
      $display("FAIL arst_clear got=%0h exp=0", {st_m, cnt_m, v_m, a_m, d_m, t_m});
    end
    reset = 1'b1;
    cap_model = 1'b0;
    q_m.delete();
    q_w1.delete();
    q_w0.delete();
    step();
  endtask

  task automatic test_clear_start();
    do_clear();
    do_start();
    do_write(5'd3, 32'd33);
    clear = 1'b1;
    start = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b0;
    cap_model = 1'b0;
    n_checks++;
    if ({st_m, cnt_m, v_m} !== '0) begin
      n_fail++;
      $display("FAIL clear_start got=%0d/%0d/%0b exp=0/0/0", st_m, cnt_m, v_m);
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_wrap();
    test_full_push_pop();
    test_halt();
    test_timeout();
    test_async_reset();
    test_clear_start();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
